// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the ALU decoder op codes consumed by hilo_muldiv, the datapath
// sizing, the FSM state encoding and small op-code classification helpers.
package hilo_muldiv_pkg;

    localparam int MD_DATA_W   = 32;
    localparam int MD_DIV_ITER = 32;

    // Op codes as produced by the ALU decoder.
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_DIV_RUN = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_DONE    = 3'd4
    } md_state_e;

    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_md_op(input logic [7:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start               load dividend/divisor and begin DIV_ITER steps
//   abort               drop any division in progress
//   dividend, divisor   unsigned operands, sampled when start is high
//   quotient, remainder results, valid the cycle after done
//   done                high in the cycle whose edge performs the final step
module hilo_muldiv_div_radix2
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W   = MD_DATA_W,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);

    localparam int CNT_W = $clog2(DIV_ITER);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dsr;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic [DATA_W:0]   trial;

    // Partial remainder with the next dividend bit shifted in, minus divisor.
    // Bit DATA_W set means the subtraction borrowed and the step restores.
    assign trial = {rem, quo[DATA_W-1]} - {1'b0, dsr};

    // Combinational so the controller can leave its run state on the same
    // edge that performs the last step.
    assign done      = busy && (count == CNT_W'(DIV_ITER - 1));
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dsr   <= divisor;
            count <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (!trial[DATA_W]) begin
                rem <= trial[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
            count <= count + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit with the HI/LO register pair.
// MULT/MULTU complete in 2 stalled cycles, DIV/DIVU in 34; MTHI/MTLO write
// directly from IDLE. Only DATA_W = DIV_ITER = 32 is supported.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   alucontrol_i    op code from the ALU decoder
//   start_i         EX-stage instruction valid
//   a_i, b_i        rs / rt operand values
//   flush_i         exception flush, aborts any operation in progress
//   stall_o         combinational pipeline hold for IF..EX
//   hi_o, lo_o      HI and LO registers
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting; accepts md ops, performs MTHI/MTLO writes
// ST_MUL     | operands latched; edge writes 64-bit product to HI/LO
// ST_DIV_RUN | divider core stepping, 32 cycles
// ST_DIV_FIX | sign / divide-by-zero correction; edge writes HI/LO
// ST_DONE    | result visible, stall released, start_i ignored
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W   = MD_DATA_W,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        alucontrol_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e         state;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              sgn;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;

    logic              idle_req;
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] div_dividend;
    logic [DATA_W-1:0] div_divisor;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_done;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] product;

    assign hi_o = hi;
    assign lo_o = lo;

    assign idle_req = (state == ST_IDLE) && start_i;
    assign stall_o  = (idle_req && is_md_op(alucontrol_i))
                    || (state == ST_MUL) || (state == ST_DIV_RUN) || (state == ST_DIV_FIX);

    // Magnitudes go straight into the core at accept time; 32'h80000000
    // negates to itself, which the unsigned core handles correctly.
    assign div_signed   = (alucontrol_i == EXE_DIV_OP);
    assign div_start    = idle_req && !flush_i && is_div_op(alucontrol_i);
    assign div_dividend = (div_signed && a_i[DATA_W-1]) ? -a_i : a_i;
    assign div_divisor  = (div_signed && b_i[DATA_W-1]) ? -b_i : b_i;

    hilo_muldiv_div_radix2 #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div_radix2 (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (flush_i),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );

    // a_neg/b_neg are only ever set for signed DIV, so no extra qualifier.
    assign q_fix = (a_neg ^ b_neg) ? -quotient : quotient;
    assign r_fix = a_neg ? -remainder : remainder;

    // Extending both operands to 2*DATA_W (sign or zero per op) makes the
    // low 2*DATA_W bits of a plain product equal the 33x33 signed product.
    assign mul_a   = {{DATA_W{sgn & op_a[DATA_W-1]}}, op_a};
    assign mul_b   = {{DATA_W{sgn & op_b[DATA_W-1]}}, op_b};
    assign product = mul_a * mul_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            hi       <= '0;
            lo       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sgn      <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (alucontrol_i)
                            EXE_MULT_OP, EXE_MULTU_OP: begin
                                op_a  <= a_i;
                                op_b  <= b_i;
                                sgn   <= (alucontrol_i == EXE_MULT_OP);
                                state <= ST_MUL;
                            end
                            EXE_DIV_OP, EXE_DIVU_OP: begin
                                op_a     <= a_i;
                                op_b     <= b_i;
                                sgn      <= div_signed;
                                a_neg    <= div_signed & a_i[DATA_W-1];
                                b_neg    <= div_signed & b_i[DATA_W-1];
                                div_zero <= (b_i == '0);
                                state    <= ST_DIV_RUN;
                            end
                            EXE_MTHI_OP: hi <= a_i;
                            EXE_MTLO_OP: lo <= a_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    {hi, lo} <= product;
                    state    <= ST_DONE;
                end
                ST_DIV_RUN: begin
                    if (div_done) begin
                        state <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    // Divide by zero bypasses the sign fix and returns the
                    // raw dividend, not its magnitude.
                    if (div_zero) begin
                        lo <= '1;
                        hi <= op_a;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
